// File: rtl/seq_multiplier.sv
//------------------------------------------------------------------------------
// seq_multiplier -- WIDTH-bit shift-add multiplier with start/busy/done handshake
//                   and optional two's-complement operation.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module seq_multiplier #(
  parameter int WIDTH     = 8,
  parameter bit SIGNED_EN = 1'b1
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 start,
  input  logic                 signed_mode,
  input  logic [WIDTH-1:0]     multiplicand,
  input  logic [WIDTH-1:0]     multiplier,
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH-1:0]   product
);

  localparam int c_CNT_W = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2
  } state_t;

  state_t               r_state;
  state_t               w_next;
  logic [WIDTH-1:0]     r_m;
  logic [WIDTH-1:0]     r_a;
  logic                 r_c;
  logic [WIDTH-1:0]     r_q;
  logic [c_CNT_W-1:0]   r_cnt;
  logic                 r_neg;
  logic                 r_done;
  logic [2*WIDTH-1:0]   r_product;

  logic                 w_signed_op;
  logic [WIDTH-1:0]     w_m_abs;
  logic [WIDTH-1:0]     w_q_abs;
  logic [WIDTH:0]       w_sum;

  // Magnitudes fit in WIDTH unsigned bits, including the most negative value.
  assign w_signed_op = SIGNED_EN && signed_mode;
  assign w_m_abs     = (w_signed_op && multiplicand[WIDTH-1]) ? -multiplicand : multiplicand;
  assign w_q_abs     = (w_signed_op && multiplier[WIDTH-1])   ? -multiplier   : multiplier;
  assign w_sum       = r_q[0] ? ({1'b0, r_a} + {1'b0, r_m}) : {r_c, r_a};

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (start) w_next = CALC;
      CALC:    if (r_cnt == c_CNT_W'(1)) w_next = FIX;
      FIX:     w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_m       <= '0;
      r_a       <= '0;
      r_c       <= 1'b0;
      r_q       <= '0;
      r_cnt     <= '0;
      r_neg     <= 1'b0;
      r_done    <= 1'b0;
      r_product <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (start) begin
            r_m   <= w_m_abs;
            r_q   <= w_q_abs;
            r_neg <= w_signed_op && (multiplicand[WIDTH-1] ^ multiplier[WIDTH-1]);
            r_a   <= '0;
            r_c   <= 1'b0;
            r_cnt <= c_CNT_W'(WIDTH);
          end
        end
        CALC: begin
          // Add-then-shift of {C,A,Q} folded into one cycle; zero enters C.
          r_c   <= 1'b0;
          r_a   <= w_sum[WIDTH:1];
          r_q   <= {w_sum[0], r_q[WIDTH-1:1]};
          r_cnt <= r_cnt - c_CNT_W'(1);
        end
        FIX: begin
          r_product <= r_neg ? -{r_a, r_q} : {r_a, r_q};
          r_done    <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign busy    = (r_state != IDLE);
  assign done    = r_done;
  assign product = r_product;

endmodule

`default_nettype wire

// File: doc/seq_multiplier.md
# seq_multiplier

Parametrised sequential shift-add multiplier with an internal sequencer. It generalises the fixed 8-bit AQ/carry accumulator register of the existing multiplier datapath to WIDTH bits and adds an optional two's-complement mode. A start/busy/done handshake replaces externally driven add/shift strobes. It sits between the operand source and the result consumer in the arithmetic datapath.

## Interface
- WIDTH, 8, operand width in bits (≥2); product is 2·WIDTH bits
- SIGNED_EN, 1, 1 = signed_mode honoured; 0 = signed_mode ignored, always unsigned
- clock  input  1  single clock, rising edge
- reset  input  1  synchronous, active-high; aborts any operation
- start  input  1  request; sampled only in IDLE
- signed_mode  input  1  1 = operands are two's complement; sampled with start
- multiplicand  input  WIDTH  M operand; sampled with start
- multiplier  input  WIDTH  Q operand; sampled with start
- busy  output  1  high from the cycle after start is accepted until done
- done  output  1  one-cycle pulse when product is updated
- product  output  2·WIDTH  registered result; holds until the next done

## Operation
- Registers: M (WIDTH), A (WIDTH), C (1), Q (WIDTH), cnt (ceil(log2(WIDTH+1))), neg (1), product (2·WIDTH), state.
- States: IDLE, CALC, FIX.
- IDLE, start=1:
  - Signed operation (signed_mode=1 and SIGNED_EN=1): M=|multiplicand|, Q=|multiplier|, neg=XOR of operand MSBs.
  - Otherwise: M=multiplicand, Q=multiplier, neg=0.
  - A=0, C=0, cnt=WIDTH, go to CALC.
  - |−2^(WIDTH−1)| = 2^(WIDTH−1) is represented as an unsigned WIDTH-bit value; no overflow.
- CALC, each cycle:
  - If Q[0]=1, {C,A} = A+M as an unsigned WIDTH+1-bit result; else {C,A} unchanged.
  - Then shift {C,A,Q} right by one, with 0 entering C, in the same cycle.
  - cnt decrements. When cnt reaches 1 (last iteration), go to FIX.
- FIX, one cycle:
  - product = neg ? −{A,Q} (mod 2^(2·WIDTH)) : {A,Q}.
  - done=1 and busy=0 take effect on this edge; go to IDLE.
- start while busy is ignored. Operands and signed_mode are not resampled during an operation.
- start in the cycle done is high is accepted, because state is IDLE.
- reset (any state): state=IDLE; busy=0, done=0, product=0, all working registers 0. A reset takes priority over a simultaneous start.
- A zero operand still runs all WIDTH iterations (fixed latency).

## Timing
- Reset values: busy=0, done=0, product=0.
- Edge E0 samples start=1 in IDLE. busy=1 after E0.
- CALC occupies edges E1..E_WIDTH.
- FIX edge E_(WIDTH+1) updates product and sets done=1, busy=0.
- Latency is WIDTH+1 clocks from the accepting edge to done/product valid: 9 for WIDTH=8, 17 for WIDTH=16.
- done is high for exactly one cycle, then clears on the next edge.
- Back-to-back: start held high continuously gives one result every WIDTH+2 clocks.
- product changes only on a FIX edge or on reset.

## Test plan
- Unsigned, WIDTH=8: multiplicand=0x55, multiplier=0x77, signed_mode=0 -> done 9 clocks after the accepting edge, product=0x2783; busy high for exactly 9 cycles.
- Unsigned extremes, WIDTH=8: 0xFF×0xFF -> 0xFE01 (carry path exercised); 0x00×0xA5 -> 0x0000 with the same 9-clock latency.
- Signed, WIDTH=8, signed_mode=1:
  - 0xFD×0x05 -> 0xFFF1
  - 0x80×0x80 -> 0x4000
  - 0x80×0x7F -> 0xC080
  - With SIGNED_EN=0, 0xFD×0x05 -> 0x04F1
- Handshake:
  - Pulse start again 3 cycles into an operation with different operands -> ignored, and the first result is unchanged.
  - Hold start high across done -> the second operation is accepted in the done cycle, and its done follows 10 clocks after the first.
- Reset mid-operation: assert reset for 1 cycle at CALC iteration 4 -> busy=0, done never pulses, product=0. A following 0x03×0x07 returns 0x0015.
- WIDTH=16 instance: 0xFFFF×0xFFFF unsigned -> 0xFFFE0001 at 17 clocks; 0x8000×0x0002 signed -> 0xFFFF0000.
